// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the data-memory access stage:
// FSM encodings, transfer-bit polarities and the ack timeout default.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic L_LOAD = 1'b1;
    localparam logic B_BYTE = 1'b1;
    localparam logic P_PRE  = 1'b1;
    localparam logic U_ADD  = 1'b1;

    localparam int TIMEOUT_DEF = 15;

    function automatic logic [31:0] ror32(
        input logic [31:0] v,
        input logic [1:0]  sh
    );
        logic [31:0] r;
        unique case (sh)
            2'd0:    r = v;
            2'd1:    r = {v[7:0],  v[31:8]};
            2'd2:    r = {v[15:0], v[31:16]};
            default: r = {v[23:0], v[31:24]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the access stage (master)
// and the memory (slave).
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_stage_byte_lane_unit.sv
// Little-endian lane steering: byte enables, store
// replication and load extract/rotate.
module byte_lane_unit
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  i_lane,
    input  logic        i_byte,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load
);

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
        o_load  = ror32(i_rdata, i_lane);
        if (i_byte == B_BYTE) begin
            o_be    = 4'b0001 << i_lane;
            o_wdata = {4{i_store_data[7:0]}};
            o_load  = {24'd0, i_rdata[{i_lane, 3'b000} +: 8]};
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Single-data-transfer stage: drives one memory access,
// then issues the rd and base register writebacks.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic        cond_pass,
    input  logic        is_mem,
    input  logic        load_store,
    input  logic        byte_or_word,
    input  logic        pre_post,
    input  logic        up_down,
    input  logic        write_back,
    input  logic        alu_wb,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [31:0] alu_result,
    input  logic [3:0]  rd,
    input  logic [3:0]  rn,
    mem_access_stage_if.master mem,
    output logic        done,
    output logic        fault,
    output logic        wb_en,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        base_wb_en,
    output logic [3:0]  base_wb_addr,
    output logic [31:0] base_wb_data
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t      r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_ea;
    logic [3:0]  r_rd;
    logic [3:0]  r_rn;
    logic [1:0]  r_lane;
    logic        r_byte;
    logic        r_load;
    logic        r_bwb;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic        r_done;
    logic        r_fault;
    logic        r_wb_en;
    logic [3:0]  r_wb_addr;
    logic [31:0] r_wb_data;
    logic        r_bwb_en;
    logic [3:0]  r_bwb_addr;
    logic [31:0] r_bwb_data;

    logic [31:0] w_ea;
    logic [31:0] w_addr;
    logic        w_idle;
    logic        w_is_load;
    logic        w_is_byte;
    logic [1:0]  w_lane;
    logic        w_byte;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;

    assign w_ea      = (up_down == U_ADD) ? base + offset
                                          : base - offset;
    assign w_addr    = (pre_post == P_PRE) ? w_ea : base;
    assign w_idle    = (r_state == S_IDLE);
    assign w_is_load = (load_store == L_LOAD);
    assign w_is_byte = (byte_or_word == B_BYTE);

    // Lanes come from live operands at issue, from the
    // captured address once the access is in flight.
    assign w_lane = w_idle ? w_addr[1:0] : r_lane;
    assign w_byte = w_idle ? w_is_byte : r_byte;

    byte_lane_unit u_lane (
        .i_lane       (w_lane),
        .i_byte       (w_byte),
        .i_store_data (store_data),
        .i_rdata      (mem.mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load       (w_load)
    );

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ea        <= '0;
            r_rd        <= '0;
            r_rn        <= '0;
            r_lane      <= '0;
            r_byte      <= 1'b0;
            r_load      <= 1'b0;
            r_bwb       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_wb_en     <= 1'b0;
            r_wb_addr   <= '0;
            r_wb_data   <= '0;
            r_bwb_en    <= 1'b0;
            r_bwb_addr  <= '0;
            r_bwb_data  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt  <= '0;
                        r_ea   <= w_ea;
                        r_rd   <= rd;
                        r_rn   <= rn;
                        r_lane <= w_addr[1:0];
                        r_byte <= w_is_byte;
                        r_load <= w_is_load;
                        // A load into the base register wins
                        // over the base update.
                        r_bwb  <= ((pre_post != P_PRE) | write_back)
                                  & ~(w_is_load & (rn == rd));
                        if (is_mem & cond_pass) begin
                            r_state     <= S_ACCESS;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= ~w_is_load;
                            r_mem_addr  <= w_is_byte ? w_addr
                                         : {w_addr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_be    <= w_be;
                        end else begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_wb_en   <= cond_pass & ~is_mem & alu_wb;
                            r_wb_addr <= rd;
                            r_wb_data <= alu_result;
                        end
                    end
                end
                S_ACCESS: begin
                    if (mem.mem_ack) begin
                        r_state    <= S_DONE;
                        r_mem_req  <= 1'b0;
                        r_done     <= 1'b1;
                        r_wb_en    <= r_load;
                        r_wb_addr  <= r_rd;
                        r_wb_data  <= w_load;
                        r_bwb_en   <= r_bwb;
                        r_bwb_addr <= r_rn;
                        r_bwb_data <= r_ea;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_state   <= S_DONE;
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_fault   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_done   <= 1'b0;
                    r_fault  <= 1'b0;
                    r_wb_en  <= 1'b0;
                    r_bwb_en <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign mem.mem_be    = r_mem_be;

    assign done         = r_done;
    assign fault        = r_fault;
    assign wb_en        = r_wb_en;
    assign wb_addr      = r_wb_addr;
    assign wb_data      = r_wb_data;
    assign base_wb_en   = r_bwb_en;
    assign base_wb_addr = r_bwb_addr;
    assign base_wb_data = r_bwb_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: word/byte loads and
// stores, timeout, mid-access reset, squash and rn==rd.
module tb_mem_access_stage;

    logic        clk;
    logic        nreset;
    logic        start;
    logic        cond_pass;
    logic        is_mem;
    logic        load_store;
    logic        byte_or_word;
    logic        pre_post;
    logic        up_down;
    logic        write_back;
    logic        alu_wb;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic [31:0] alu_result;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic        done;
    logic        fault;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        base_wb_en;
    logic [3:0]  base_wb_addr;
    logic [31:0] base_wb_data;

    int total = 0;
    int bad   = 0;

    mem_access_stage_if mif ();

    mem_access_stage #(.TIMEOUT(15)) dut (
        .clk          (clk),
        .nreset       (nreset),
        .start        (start),
        .cond_pass    (cond_pass),
        .is_mem       (is_mem),
        .load_store   (load_store),
        .byte_or_word (byte_or_word),
        .pre_post     (pre_post),
        .up_down      (up_down),
        .write_back   (write_back),
        .alu_wb       (alu_wb),
        .base         (base),
        .offset       (offset),
        .store_data   (store_data),
        .alu_result   (alu_result),
        .rd           (rd),
        .rn           (rn),
        .mem          (mif),
        .done         (done),
        .fault        (fault),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .base_wb_en   (base_wb_en),
        .base_wb_addr (base_wb_addr),
        .base_wb_data (base_wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic c, input logic m,
                         input logic l, input logic b,
                         input logic p, input logic u,
                         input logic w,
                         input logic [31:0] bs,
                         input logic [31:0] of,
                         input logic [3:0] d,
                         input logic [3:0] n);
        cond_pass    = c;
        is_mem       = m;
        load_store   = l;
        byte_or_word = b;
        pre_post     = p;
        up_down      = u;
        write_back   = w;
        base         = bs;
        offset       = of;
        rd           = d;
        rn           = n;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    initial begin
        int n;
        nreset = 1'b1;
        start = 1'b0; cond_pass = 1'b0; is_mem = 1'b0;
        load_store = 1'b0; byte_or_word = 1'b0;
        pre_post = 1'b0; up_down = 1'b0; write_back = 1'b0;
        alu_wb = 1'b0; base = '0; offset = '0;
        store_data = '0; alu_result = '0; rd = '0; rn = '0;
        mif.mem_rdata = '0; mif.mem_ack = 1'b0;
        #1;
        chk("rst_req", 32'(mif.mem_req), 0);
        chk("rst_done", 32'(done), 0);
        tick(); tick();
        nreset = 1'b0;
        chk("rst_wb", 32'(wb_en), 0);
        chk("rst_bwb", 32'(base_wb_en), 0);

        // LDR word pre-indexed, ack on first access cycle
        issue(1, 1, 1, 0, 1, 1, 0, 32'h100, 32'h4, 4'd3, 4'd1);
        chk("ldr_req", 32'(mif.mem_req), 1);
        chk("ldr_we", 32'(mif.mem_we), 0);
        chk("ldr_addr", mif.mem_addr, 32'h104);
        chk("ldr_be", 32'(mif.mem_be), 32'hF);
        chk("ldr_nodone1", 32'(done), 0);
        mif.mem_rdata = 32'hDEADBEEF; mif.mem_ack = 1'b1;
        tick();
        mif.mem_ack = 1'b0;
        chk("ldr_done2", 32'(done), 1);
        chk("ldr_wben", 32'(wb_en), 1);
        chk("ldr_wbaddr", 32'(wb_addr), 3);
        chk("ldr_wbdata", wb_data, 32'hDEADBEEF);
        chk("ldr_bwb", 32'(base_wb_en), 0);
        chk("ldr_fault", 32'(fault), 0);
        chk("ldr_req_off", 32'(mif.mem_req), 0);
        tick();
        chk("ldr_done_pulse", 32'(done), 0);
        chk("ldr_wb_pulse", 32'(wb_en), 0);

        // STRB post-indexed down, ack after one wait cycle
        store_data = 32'h123456AB;
        issue(1, 1, 0, 1, 0, 0, 0, 32'h203, 32'h3, 4'd5, 4'd4);
        chk("strb_we", 32'(mif.mem_we), 1);
        chk("strb_addr", mif.mem_addr, 32'h203);
        chk("strb_be", 32'(mif.mem_be), 32'h8);
        chk("strb_wdata", mif.mem_wdata, 32'hABABABAB);
        store_data = 32'h0;
        tick();
        chk("strb_hold_req", 32'(mif.mem_req), 1);
        chk("strb_hold_addr", mif.mem_addr, 32'h203);
        chk("strb_hold_wd", mif.mem_wdata, 32'hABABABAB);
        chk("strb_nodone", 32'(done), 0);
        mif.mem_ack = 1'b1;
        tick();
        mif.mem_ack = 1'b0;
        chk("strb_done", 32'(done), 1);
        chk("strb_wben", 32'(wb_en), 0);
        chk("strb_bwben", 32'(base_wb_en), 1);
        chk("strb_bwbaddr", 32'(base_wb_addr), 4);
        chk("strb_bwbdata", base_wb_data, 32'h200);
        tick();

        // LDR word at 0x102 rotates right by 16
        issue(1, 1, 1, 0, 1, 1, 0, 32'h100, 32'h2, 4'd6, 4'd1);
        chk("ldrrot_addr", mif.mem_addr, 32'h100);
        mif.mem_rdata = 32'h11223344; mif.mem_ack = 1'b1;
        tick();
        mif.mem_ack = 1'b0;
        chk("ldrrot_data", wb_data, 32'h33441122);
        tick();

        // LDRB at 0x101 extracts lane 1
        issue(1, 1, 1, 1, 1, 1, 0, 32'h100, 32'h1, 4'd6, 4'd1);
        chk("ldrb_addr", mif.mem_addr, 32'h101);
        chk("ldrb_be", 32'(mif.mem_be), 32'h2);
        mif.mem_ack = 1'b1;
        tick();
        mif.mem_ack = 1'b0;
        chk("ldrb_data", wb_data, 32'h00000033);
        tick();

        // Stray ack while idle is ignored
        mif.mem_ack = 1'b1;
        tick();
        mif.mem_ack = 1'b0;
        chk("idle_ack_done", 32'(done), 0);
        chk("idle_ack_req", 32'(mif.mem_req), 0);

        // Ack withheld: timeout after 15 access cycles
        issue(1, 1, 1, 0, 1, 1, 1, 32'h300, 32'h4, 4'd8, 4'd9);
        n = 0;
        while (mif.mem_req && n < 40) begin
            n++;
            tick();
        end
        chk("to_cycles", 32'(n), 15);
        chk("to_done", 32'(done), 1);
        chk("to_fault", 32'(fault), 1);
        chk("to_wben", 32'(wb_en), 0);
        chk("to_bwben", 32'(base_wb_en), 0);
        tick();
        chk("to_fault_clr", 32'(fault), 0);

        // Reset on the third access cycle
        issue(1, 1, 1, 0, 1, 1, 0, 32'h400, 32'h0, 4'd1, 4'd2);
        tick(); tick();
        chk("rstmid_req_pre", 32'(mif.mem_req), 1);
        #2 nreset = 1'b1;
        #1;
        chk("rstmid_req", 32'(mif.mem_req), 0);
        mif.mem_ack = 1'b1;
        tick();
        mif.mem_ack = 1'b0;
        chk("rstmid_nodone", 32'(done), 0);
        nreset = 1'b0;
        alu_wb = 1'b1; alu_result = 32'hCAFEF00D;
        issue(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd7, 4'd0);
        alu_wb = 1'b0;
        chk("alu_done1", 32'(done), 1);
        chk("alu_wben", 32'(wb_en), 1);
        chk("alu_wbaddr", 32'(wb_addr), 7);
        chk("alu_wbdata", wb_data, 32'hCAFEF00D);
        chk("alu_noreq", 32'(mif.mem_req), 0);
        tick();

        // Squashed LDR with rn==rd
        issue(0, 1, 1, 0, 1, 1, 1, 32'h500, 32'h4, 4'd2, 4'd2);
        chk("sq_done1", 32'(done), 1);
        chk("sq_noreq", 32'(mif.mem_req), 0);
        chk("sq_wben", 32'(wb_en), 0);
        chk("sq_bwben", 32'(base_wb_en), 0);
        tick();

        // LDR rn==rd=2 with writeback: load wins
        issue(1, 1, 1, 0, 1, 1, 1, 32'h500, 32'h4, 4'd2, 4'd2);
        chk("rnrd_req", 32'(mif.mem_req), 1);
        mif.mem_rdata = 32'h0BADF00D; mif.mem_ack = 1'b1;
        tick();
        mif.mem_ack = 1'b0;
        chk("rnrd_done", 32'(done), 1);
        chk("rnrd_wben", 32'(wb_en), 1);
        chk("rnrd_wbaddr", 32'(wb_addr), 2);
        chk("rnrd_bwben", 32'(base_wb_en), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum ACCESS cycles spent waiting for mem_ack.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port nreset, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: one-cycle pulse from the CPU controller (data-memory state); operands valid.
REQ-005 SHALL have port cond_pass, input, 1: condition test result; 0 = instruction squashed.
REQ-006 SHALL have ports is_mem, load_store, byte_or_word, pre_post, up_down, write_back, alu_wb, each input, 1: single-data-transfer flag, L (1=load), B (1=byte), P (1=pre), U (1=add), W, and "non-memory op writes rd".
REQ-007 SHALL have ports base, offset, store_data, alu_result, each input, 32: Rn data, shifted offset, Rd data, ALU result.
REQ-008 SHALL have ports rd and rn, input, 4: destination and base register numbers.
REQ-009 SHALL have ports mem_req, mem_we, mem_addr (32), mem_wdata (32), mem_be (4), each output: data-memory request.
REQ-010 SHALL have ports mem_rdata (32) and mem_ack (1), inputs: memory response.
REQ-011 SHALL have ports done (1) and fault (1), outputs: completion pulse and timeout flag.
REQ-012 SHALL have ports wb_en (1), wb_addr (4), wb_data (32), base_wb_en (1), base_wb_addr (4), base_wb_data (32), outputs: two register-file write requests.

Function
REQ-013 SHALL register all inputs of REQ-005..REQ-008 on start while IDLE; start in any other state SHALL be ignored.
REQ-014 SHALL compute ea = up_down ? base+offset : base-offset, modulo 2^32; access address = pre_post ? ea : base.
REQ-015 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE for is_mem=1 and cond_pass=1; otherwise IDLE -> DONE -> IDLE.
REQ-016 In ACCESS, SHALL hold mem_req=1 with stable mem_we, mem_addr, mem_wdata and mem_be until mem_ack is sampled high, then SHALL enter DONE.
REQ-017 Latency: with ack on the first ACCESS cycle, done SHALL assert 2 cycles after start; the non-memory path SHALL assert done 1 cycle after start.
REQ-018 Word access: mem_addr[1:0]=00, mem_be=1111; a word load SHALL rotate mem_rdata right by 8*addr[1:0].
REQ-019 Byte store: mem_be SHALL be one-hot at lane addr[1:0] (little-endian), with mem_wdata = store_data[7:0] replicated 4 times.
REQ-020 Byte load: wb_data SHALL be the selected lane, zero-extended.
REQ-021 done, wb_en and base_wb_en SHALL be high for exactly the single DONE cycle; the data outputs SHALL be valid in that cycle.
REQ-022 Load: wb_en=1, wb_addr=rd, wb_data=loaded value. Store: wb_en=0.
REQ-023 base_wb_en SHALL be 1 when pre_post=0 or write_back=1, with base_wb_data=ea and base_wb_addr=rn.
REQ-024 On a load with rn==rd, base_wb_en SHALL be 0 (load wins).
REQ-025 Non-memory op with cond_pass=1: wb_en=alu_wb, wb_data=alu_result, wb_addr=rd. cond_pass=0: no writes and no mem_req.
REQ-026 If mem_ack is not seen within TIMEOUT ACCESS cycles, SHALL enter DONE with fault=1 and wb_en=base_wb_en=0.
REQ-027 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-028 nreset high SHALL asynchronously force IDLE and drive every output to 0, including mem_req mid-access.
REQ-029 After nreset falls, the block SHALL accept start on the next rising edge.

Structure
REQ-030 FSM state encodings, L/B/P/U bit polarities and the TIMEOUT default SHALL live in the shared CPU definitions package/header.
REQ-031 Lane logic (byte-enable generation, store replication, load extract/rotate) SHALL be one combinational sub-module, byte_lane_unit.
REQ-032 RTL SHALL total 120-400 lines.

Verification
REQ-033 LDR word, P=1 U=1 W=0, base=0x100, offset=4, mem_rdata=0xDEADBEEF, ack on first ACCESS cycle -> mem_addr=0x104, be=1111, done at start+2, wb_data=0xDEADBEEF, base_wb_en=0.
REQ-034 STRB, P=0 U=0, base=0x203, offset=3, store_data=0x1234_56AB -> mem_addr=0x203, be=1000, wdata=0xABABABAB, base_wb_data=0x200, wb_en=0.
REQ-035 LDR word at 0x102, mem_rdata=0x11223344 -> wb_data=0x33441122. LDRB at 0x101 -> wb_data=0x00000033.
REQ-036 mem_ack withheld with TIMEOUT=15 -> mem_req high for 15 cycles, then done=1 and fault=1 with no writebacks.
REQ-037 nreset pulsed on the 3rd ACCESS cycle -> mem_req=0 immediately, no done, and a new start is accepted after release.
REQ-038 cond_pass=0 LDR with rn==rd, then LDR with rn==rd=2, W=1 -> first: done at start+1 with no req and no writes; second: only wb_en set.
